// File: rtl/conv2d_job_scheduler_pkg.sv
// Shared definitions for the conv2d job scheduler: FSM states, completion
// error codes and small arithmetic helpers.
package conv2d_job_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_RUN       = 3'd3,
      ST_REPORT    = 3'd4
   } sched_state_e;

   localparam logic [1:0] ERR_OK         = 2'd0;
   localparam logic [1:0] ERR_BAD_DIM    = 2'd1;
   localparam logic [1:0] ERR_START_FAIL = 2'd2;

   // Width of the four 32-bit scalar job parameters packed together.
   localparam int unsigned PARAM_W = 128;

   // Cycle counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // A feature-map dimension is usable when it is non-zero and within range.
   function automatic logic dim_ok(input logic [31:0] dim, input logic [31:0] max_dim);
      return (dim != 32'd0) && (dim <= max_dim);
   endfunction

endpackage

// File: rtl/conv2d_job_scheduler_fifo.sv
// Command queue: first-in first-out descriptor store with an occupancy count.
// A flush empties the queue; an enqueue in the flush cycle is discarded.
module conv2d_job_scheduler_fifo #(
   parameter int WIDTH    = 132,
   parameter int LOGDEPTH = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic                pop,
   input  logic                flush,
   input  logic [WIDTH-1:0]    wdata,
   output logic [WIDTH-1:0]    rdata,
   output logic                full,
   output logic                empty,
   output logic [LOGDEPTH:0]   count
);

   localparam int DEPTH = 1 << LOGDEPTH;

   logic [WIDTH-1:0]    mem_r [DEPTH];
   logic [LOGDEPTH-1:0] wr_ptr_r;
   logic [LOGDEPTH-1:0] rd_ptr_r;
   logic [LOGDEPTH:0]   count_r;
   logic                push_s;
   logic                pop_s;

   assign full   = (count_r == (LOGDEPTH+1)'(DEPTH));
   assign empty  = (count_r == '0);
   assign count  = count_r;
   assign rdata  = mem_r[rd_ptr_r];
   assign push_s = push & ~full & ~flush;
   assign pop_s  = pop & ~empty;

   // Descriptor storage, cleared on reset so stale data never reaches the engine.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Read/write pointers and occupancy; flush wins over any same-cycle push.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + LOGDEPTH'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + LOGDEPTH'(1);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (LOGDEPTH+1)'(1);
            2'b01:   count_r <= count_r - (LOGDEPTH+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/conv2d_job_scheduler.sv
// Job-level controller between the MMIO command path and the conv2d engine:
// queues descriptors, validates them, launches the engine with a one-cycle
// start pulse, tracks completion via eng_idle and returns completion records.
module conv2d_job_scheduler #(
   parameter int LOGDEPTH   = 2,
   parameter int MAX_FM_DIM = 64,
   parameter int TAGW       = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [TAGW-1:0]     cmd_tag,
   input  logic [31:0]         cmd_fm_dim,
   input  logic [31:0]         cmd_wt_offset,
   input  logic [31:0]         cmd_ifm_offset,
   input  logic [31:0]         cmd_ofm_offset,
   input  logic                flush,
   output logic                eng_start,
   input  logic                eng_idle,
   output logic [31:0]         eng_fm_dim,
   output logic [31:0]         eng_wt_offset,
   output logic [31:0]         eng_ifm_offset,
   output logic [31:0]         eng_ofm_offset,
   output logic                done_valid,
   input  logic                done_ready,
   output logic [TAGW-1:0]     done_tag,
   output logic [1:0]          done_err,
   output logic [31:0]         done_cycles,
   output logic                busy,
   output logic [LOGDEPTH:0]   pending
);

   import conv2d_job_scheduler_pkg::*;

   localparam int QW = TAGW + PARAM_W;

   sched_state_e      state_r, state_nxt_s;
   logic [QW-1:0]     head_s;
   logic              full_s, empty_s, pop_s, load_done_s;
   logic [TAGW-1:0]   act_tag_r, done_tag_nxt_s;
   logic [31:0]       act_fm_dim_r, act_wt_r, act_ifm_r, act_ofm_r;
   logic [31:0]       cnt_r, done_cyc_nxt_s;
   logic [1:0]        done_err_nxt_s;
   logic              eng_start_r, done_valid_r;
   logic [TAGW-1:0]   done_tag_r;
   logic [1:0]        done_err_r;
   logic [31:0]       done_cycles_r;

   conv2d_job_scheduler_fifo #(.WIDTH(QW), .LOGDEPTH(LOGDEPTH)) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid),
      .pop   (pop_s),
      .flush (flush),
      .wdata ({cmd_tag, cmd_fm_dim, cmd_wt_offset, cmd_ifm_offset, cmd_ofm_offset}),
      .rdata (head_s),
      .full  (full_s),
      .empty (empty_s),
      .count (pending)
   );

   assign cmd_ready      = ~full_s;
   assign busy           = (state_r != ST_IDLE) | ~empty_s;
   assign eng_start      = eng_start_r;
   assign eng_fm_dim     = act_fm_dim_r;
   assign eng_wt_offset  = act_wt_r;
   assign eng_ifm_offset = act_ifm_r;
   assign eng_ofm_offset = act_ofm_r;
   assign done_valid     = done_valid_r;
   assign done_tag       = done_tag_r;
   assign done_err       = done_err_r;
   assign done_cycles    = done_cycles_r;

   // Next-state decode, queue pop and completion-record selection.
   always_comb begin
      state_nxt_s    = state_r;
      pop_s          = 1'b0;
      load_done_s    = 1'b0;
      done_tag_nxt_s = act_tag_r;
      done_err_nxt_s = ERR_OK;
      done_cyc_nxt_s = 32'd0;
      case (state_r)
         ST_IDLE: begin
            if (!empty_s && eng_idle) begin
               pop_s = 1'b1;
               if (dim_ok(head_s[PARAM_W-1 -: 32], 32'(MAX_FM_DIM))) begin
                  state_nxt_s = ST_ISSUE;
               end else begin
                  // Rejected job never touches the engine; report it straight away.
                  state_nxt_s    = ST_REPORT;
                  load_done_s    = 1'b1;
                  done_tag_nxt_s = head_s[QW-1 -: TAGW];
                  done_err_nxt_s = ERR_BAD_DIM;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_nxt_s = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (eng_idle) begin
               state_nxt_s    = ST_REPORT;
               load_done_s    = 1'b1;
               done_err_nxt_s = ERR_START_FAIL;
               done_cyc_nxt_s = sat_inc(cnt_r);
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_RUN: begin
            if (eng_idle) begin
               state_nxt_s    = ST_REPORT;
               load_done_s    = 1'b1;
               done_cyc_nxt_s = sat_inc(cnt_r);
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_REPORT: begin
            if (done_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_REPORT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_r <= ST_IDLE;
      else      state_r <= state_nxt_s;
   end

   // Active job parameters; loaded only on a pop, so they hold through REPORT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         act_tag_r    <= '0;
         act_fm_dim_r <= 32'd0;
         act_wt_r     <= 32'd0;
         act_ifm_r    <= 32'd0;
         act_ofm_r    <= 32'd0;
      end else if (pop_s) begin
         {act_tag_r, act_fm_dim_r, act_wt_r, act_ifm_r, act_ofm_r} <= head_s;
      end
   end

   // Job cycle counter: restarts at 1 in ISSUE, saturating count afterwards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r <= 32'd0;
      end else if (state_r == ST_ISSUE) begin
         cnt_r <= 32'd1;
      end else if ((state_r == ST_WAIT_BUSY) || (state_r == ST_RUN)) begin
         cnt_r <= sat_inc(cnt_r);
      end
   end

   // Registered start pulse and completion record.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         eng_start_r   <= 1'b0;
         done_valid_r  <= 1'b0;
         done_tag_r    <= '0;
         done_err_r    <= ERR_OK;
         done_cycles_r <= 32'd0;
      end else begin
         eng_start_r  <= (state_nxt_s == ST_ISSUE);
         done_valid_r <= (state_nxt_s == ST_REPORT);
         if (load_done_s) begin
            done_tag_r    <= done_tag_nxt_s;
            done_err_r    <= done_err_nxt_s;
            done_cycles_r <= done_cyc_nxt_s;
         end
      end
   end

endmodule

// File: tb/tb_conv2d_job_scheduler.sv
// Directed self-checking bench for conv2d_job_scheduler with a small
// behavioural engine model (configurable run length, stall, start-ignore).
module tb_conv2d_job_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_tag = 4'd0;
   logic [31:0] cmd_fm_dim = 32'd0;
   logic [31:0] cmd_wt_offset = 32'd0;
   logic [31:0] cmd_ifm_offset = 32'd0;
   logic [31:0] cmd_ofm_offset = 32'd0;
   logic        flush = 1'b0;
   logic        eng_start;
   logic        eng_idle;
   logic [31:0] eng_fm_dim, eng_wt_offset, eng_ifm_offset, eng_ofm_offset;
   logic        done_valid;
   logic        done_ready = 1'b0;
   logic [3:0]  done_tag;
   logic [1:0]  done_err;
   logic [31:0] done_cycles;
   logic        busy;
   logic [2:0]  pending;

   int n_checks = 0;
   int n_fail   = 0;

   // Engine model controls
   int eng_cnt = 0;
   int eng_run_len = 100;
   bit eng_hold_busy = 1'b0;
   bit eng_ignore_start = 1'b0;
   int start_count = 0;

   conv2d_job_scheduler #(.LOGDEPTH(2), .MAX_FM_DIM(64), .TAGW(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tag(cmd_tag),
      .cmd_fm_dim(cmd_fm_dim), .cmd_wt_offset(cmd_wt_offset),
      .cmd_ifm_offset(cmd_ifm_offset), .cmd_ofm_offset(cmd_ofm_offset),
      .flush(flush), .eng_start(eng_start), .eng_idle(eng_idle),
      .eng_fm_dim(eng_fm_dim), .eng_wt_offset(eng_wt_offset),
      .eng_ifm_offset(eng_ifm_offset), .eng_ofm_offset(eng_ofm_offset),
      .done_valid(done_valid), .done_ready(done_ready), .done_tag(done_tag),
      .done_err(done_err), .done_cycles(done_cycles), .busy(busy), .pending(pending)
   );

   always #5 clk = ~clk;

   // Engine: goes busy the cycle after a start and stays busy eng_run_len cycles.
   always @(posedge clk or negedge rst) begin
      if (!rst)                                eng_cnt <= 0;
      else if (eng_start && !eng_ignore_start) eng_cnt <= eng_run_len;
      else if (eng_cnt > 0)                    eng_cnt <= eng_cnt - 1;
   end
   assign eng_idle = (eng_cnt == 0) && !eng_hold_busy;

   // Count start pulses seen by the engine.
   always @(posedge clk) begin
      if (rst && eng_start) start_count <= start_count + 1;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_job(input logic [3:0] tag, input logic [31:0] dim);
      int w = 0;
      while (!cmd_ready && w < 300) begin tick(); w++; end
      n_checks++;
      if (!cmd_ready) begin n_fail++; $display("FAIL push_ready tag %0d: cmd_ready got 0 expected 1", tag); end
      cmd_valid      = 1'b1;
      cmd_tag        = tag;
      cmd_fm_dim     = dim;
      cmd_wt_offset  = 32'h1000_0000 + 32'(tag);
      cmd_ifm_offset = 32'h2000_0000 + 32'(tag);
      cmd_ofm_offset = 32'h3000_0000 + 32'(tag);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_start(output bit ok);
      int w = 0;
      while (!eng_start && w < 300) begin tick(); w++; end
      ok = eng_start;
   endtask

   task automatic collect_done(output logic [3:0] tag, output logic [1:0] err,
                               output logic [31:0] cyc, output bit ok);
      int w = 0;
      while (!done_valid && w < 500) begin tick(); w++; end
      ok  = done_valid;
      tag = done_tag;
      err = done_err;
      cyc = done_cycles;
      if (ok) begin
         done_ready = 1'b1;
         tick();
         done_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      tick(3);
      n_checks++;
      if (cmd_ready !== 1'b1 || eng_start !== 1'b0 || done_valid !== 1'b0 || busy !== 1'b0 || pending !== 3'd0) begin
         n_fail++; $display("FAIL reset_ctrl: got ready=%b start=%b dv=%b busy=%b pend=%0d expected 1 0 0 0 0",
                            cmd_ready, eng_start, done_valid, busy, pending);
      end
      n_checks++;
      if (eng_fm_dim !== 32'd0 || eng_wt_offset !== 32'd0 || eng_ifm_offset !== 32'd0 || eng_ofm_offset !== 32'd0 ||
          done_tag !== 4'd0 || done_err !== 2'd0 || done_cycles !== 32'd0) begin
         n_fail++; $display("FAIL reset_data: got dim=%0d tag=%0d err=%0d cyc=%0d expected all 0",
                            eng_fm_dim, done_tag, done_err, done_cycles);
      end
      rst = 1'b1;
      tick(2);
   endtask

   task automatic test_single_job();
      logic [3:0] t; logic [1:0] e; logic [31:0] c; bit ok; int s0;
      s0 = start_count;
      eng_run_len = 100;
      push_job(4'd3, 32'd8);
      n_checks++;
      if (eng_start !== 1'b0) begin n_fail++; $display("FAIL single_start_t1: got %b expected 0", eng_start); end
      tick();
      n_checks++;
      if (eng_start !== 1'b1) begin n_fail++; $display("FAIL single_start_t2: got %b expected 1", eng_start); end
      n_checks++;
      if (eng_fm_dim !== 32'd8 || eng_wt_offset !== 32'h1000_0003 || eng_ofm_offset !== 32'h3000_0003) begin
         n_fail++; $display("FAIL single_params: got dim=%0d wt=%h ofm=%h expected 8 10000003 30000003",
                            eng_fm_dim, eng_wt_offset, eng_ofm_offset);
      end
      tick();
      n_checks++;
      if (eng_start !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL single_pulse_end: got start=%b busy=%b expected 0 1", eng_start, busy);
      end
      collect_done(t, e, c, ok);
      n_checks++;
      if (!ok || t !== 4'd3 || e !== 2'd0 || c !== 32'd102) begin
         n_fail++; $display("FAIL single_done: got ok=%0d tag=%0d err=%0d cyc=%0d expected 1 3 0 102", ok, t, e, c);
      end
      n_checks++;
      if (start_count - s0 !== 1) begin n_fail++; $display("FAIL single_nstart: got %0d expected 1", start_count - s0); end
   endtask

   task automatic test_bad_dims();
      logic [3:0] t; logic [1:0] e; logic [31:0] c; bit ok; int s0;
      s0 = start_count;
      push_job(4'd5, 32'd0);
      push_job(4'd6, 32'd65);
      collect_done(t, e, c, ok);
      n_checks++;
      if (!ok || t !== 4'd5 || e !== 2'd1 || c !== 32'd0) begin
         n_fail++; $display("FAIL bad_dim_zero: got ok=%0d tag=%0d err=%0d cyc=%0d expected 1 5 1 0", ok, t, e, c);
      end
      collect_done(t, e, c, ok);
      n_checks++;
      if (!ok || t !== 4'd6 || e !== 2'd1 || c !== 32'd0) begin
         n_fail++; $display("FAIL bad_dim_big: got ok=%0d tag=%0d err=%0d cyc=%0d expected 1 6 1 0", ok, t, e, c);
      end
      n_checks++;
      if (start_count !== s0) begin n_fail++; $display("FAIL bad_dim_nostart: got %0d starts expected 0", start_count - s0); end
   endtask

   task automatic test_queue_full();
      logic [3:0] t; logic [1:0] e; logic [31:0] c; bit ok;
      eng_hold_busy = 1'b1;
      eng_run_len   = 3;
      for (int i = 1; i <= 4; i++) push_job(4'(i), 32'd4);
      n_checks++;
      if (cmd_ready !== 1'b0 || pending !== 3'd4 || busy !== 1'b1) begin
         n_fail++; $display("FAIL full_state: got ready=%b pend=%0d busy=%b expected 0 4 1", cmd_ready, pending, busy);
      end
      cmd_valid = 1'b1; cmd_tag = 4'd5; cmd_fm_dim = 32'd4;
      tick(3);
      n_checks++;
      if (pending !== 3'd4 || cmd_ready !== 1'b0) begin
         n_fail++; $display("FAIL full_hold: got pend=%0d ready=%b expected 4 0", pending, cmd_ready);
      end
      cmd_valid = 1'b0;
      eng_hold_busy = 1'b0;
      push_job(4'd5, 32'd4);
      for (int i = 1; i <= 5; i++) begin
         collect_done(t, e, c, ok);
         n_checks++;
         if (!ok || t !== 4'(i) || e !== 2'd0 || c !== 32'd5) begin
            n_fail++; $display("FAIL full_drain_%0d: got ok=%0d tag=%0d err=%0d cyc=%0d expected 1 %0d 0 5", i, ok, t, e, c, i);
         end
      end
   endtask

   task automatic test_start_fail();
      logic [3:0] t; logic [1:0] e; logic [31:0] c; bit ok;
      eng_ignore_start = 1'b1;
      push_job(4'd9, 32'd16);
      collect_done(t, e, c, ok);
      n_checks++;
      if (!ok || t !== 4'd9 || e !== 2'd2 || c !== 32'd2) begin
         n_fail++; $display("FAIL start_fail: got ok=%0d tag=%0d err=%0d cyc=%0d expected 1 9 2 2", ok, t, e, c);
      end
      eng_ignore_start = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [3:0] t; logic [1:0] e; logic [31:0] c; bit ok; int s0; int w;
      eng_run_len = 5;
      push_job(4'd10, 32'd10);
      push_job(4'd11, 32'd10);
      n_checks++;
      if (pending !== 3'd1) begin n_fail++; $display("FAIL push_pop_same_cycle: pending got %0d expected 1", pending); end
      push_job(4'd12, 32'd10);
      w = 0;
      while (!done_valid && w < 200) begin tick(); w++; end
      s0 = start_count;
      for (int i = 0; i < 20; i++) begin
         n_checks++;
         if (done_valid !== 1'b1 || done_tag !== 4'd10 || done_err !== 2'd0 || done_cycles !== 32'd7 ||
             pending !== 3'd2 || start_count !== s0) begin
            n_fail++; $display("FAIL backpressure_c%0d: got dv=%b tag=%0d err=%0d cyc=%0d pend=%0d nstart=%0d expected 1 10 0 7 2 0",
                               i, done_valid, done_tag, done_err, done_cycles, pending, start_count - s0);
         end
         tick();
      end
      for (int i = 10; i <= 12; i++) begin
         collect_done(t, e, c, ok);
         n_checks++;
         if (!ok || t !== 4'(i) || e !== 2'd0 || c !== 32'd7) begin
            n_fail++; $display("FAIL backpressure_drain_%0d: got ok=%0d tag=%0d cyc=%0d expected 1 %0d 7", i, ok, t, c, i);
         end
      end
   endtask

   task automatic test_flush();
      logic [3:0] t; logic [1:0] e; logic [31:0] c; bit ok; int s0;
      s0 = start_count;
      eng_run_len = 50;
      push_job(4'd13, 32'd8);
      wait_start(ok);
      push_job(4'd14, 32'd8);
      push_job(4'd15, 32'd8);
      push_job(4'd1, 32'd8);
      n_checks++;
      if (pending !== 3'd3) begin n_fail++; $display("FAIL flush_pre: pending got %0d expected 3", pending); end
      flush = 1'b1; cmd_valid = 1'b1; cmd_tag = 4'd2; cmd_fm_dim = 32'd8;
      tick();
      flush = 1'b0; cmd_valid = 1'b0;
      n_checks++;
      if (pending !== 3'd0 || cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL flush_empty: got pend=%0d ready=%b expected 0 1", pending, cmd_ready);
      end
      collect_done(t, e, c, ok);
      n_checks++;
      if (!ok || t !== 4'd13 || e !== 2'd0 || c !== 32'd52) begin
         n_fail++; $display("FAIL flush_running: got ok=%0d tag=%0d err=%0d cyc=%0d expected 1 13 0 52", ok, t, e, c);
      end
      tick(10);
      n_checks++;
      if (start_count - s0 !== 1 || busy !== 1'b0 || done_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_after: got nstart=%0d busy=%b dv=%b expected 1 0 0", start_count - s0, busy, done_valid);
      end
   endtask

   task automatic test_reset_mid_job();
      bit ok; int s0;
      eng_run_len = 50;
      push_job(4'd7, 32'd8);
      wait_start(ok);
      push_job(4'd8, 32'd8);
      tick(10);
      rst = 1'b0;
      #1;
      n_checks++;
      if (cmd_ready !== 1'b1 || eng_start !== 1'b0 || done_valid !== 1'b0 || busy !== 1'b0 || pending !== 3'd0) begin
         n_fail++; $display("FAIL midrst_ctrl: got ready=%b start=%b dv=%b busy=%b pend=%0d expected 1 0 0 0 0",
                            cmd_ready, eng_start, done_valid, busy, pending);
      end
      n_checks++;
      if (eng_fm_dim !== 32'd0 || eng_wt_offset !== 32'd0 || eng_ifm_offset !== 32'd0 || eng_ofm_offset !== 32'd0 ||
          done_tag !== 4'd0 || done_err !== 2'd0 || done_cycles !== 32'd0) begin
         n_fail++; $display("FAIL midrst_data: got dim=%0d wt=%h tag=%0d cyc=%0d expected all 0",
                            eng_fm_dim, eng_wt_offset, done_tag, done_cycles);
      end
      tick(2);
      rst = 1'b1;
      s0 = start_count;
      tick(5);
      n_checks++;
      if (start_count !== s0 || busy !== 1'b0 || done_valid !== 1'b0) begin
         n_fail++; $display("FAIL midrst_quiet: got nstart=%0d busy=%b dv=%b expected 0 0 0", start_count - s0, busy, done_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single_job();
      test_bad_dims();
      test_queue_full();
      test_start_fail();
      test_backpressure();
      test_flush();
      test_reset_mid_job();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/conv2d_job_scheduler.md
# conv2D_job_scheduler

Job-level controller that sits between the CPU's MMIO command path and the conv2D compute engine. It queues convolution job descriptors, checks each one, launches it with a one-cycle start pulse, and holds the scalar parameters stable while the job runs. It watches the engine's idle output to detect completion and returns one completion record per job, carrying a tag, an error code and a cycle count.

## Interface
- `LOGDEPTH`, default 2: command queue depth is 2^LOGDEPTH entries.
- `MAX_FM_DIM`, default 64: largest accepted feature-map dimension.
- `TAGW`, default 4: job tag width.
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `cmd_valid`  in  1  job descriptor valid.
- `cmd_ready`  out  1  queue can accept a descriptor; equals queue not full.
- `cmd_tag`  in  TAGW  caller's job identifier.
- `cmd_fm_dim`  in  32  feature-map dimension.
- `cmd_wt_offset`, `cmd_ifm_offset`, `cmd_ofm_offset`  in  32 each  memory offsets.
- `flush`  in  1  drops every queued job that has not been issued.
- `eng_start`  out  1  one-cycle start pulse to the engine.
- `eng_idle`  in  1  engine idle status.
- `eng_fm_dim`, `eng_wt_offset`, `eng_ifm_offset`, `eng_ofm_offset`  out  32 each  parameters of the active job.
- `done_valid`  out  1  completion record valid.
- `done_ready`  in  1  consumer accepts the record.
- `done_tag`  out  TAGW  tag of the completed job.
- `done_err`  out  2  0 = OK, 1 = BAD_DIM, 2 = START_FAIL.
- `done_cycles`  out  32  cycle count of the job.
- `busy`  out  1  state is not IDLE, or the queue is non-empty.
- `pending`  out  LOGDEPTH+1  number of queued jobs.

## Operation
- **Queue.** A descriptor is accepted on `cmd_valid & cmd_ready`. The queue is first-in, first-out.
- **Flush.** When `flush` is high, occupancy goes to 0 on the next cycle. The job currently issued is unaffected. Any enqueue in the same cycle is discarded.
- **State machine.** States are IDLE, ISSUE, WAIT_BUSY, RUN and REPORT.
- **IDLE.** Waits until the queue is non-empty and `eng_idle` = 1, then pops the head into the active registers.
  - If `fm_dim` is 0 or greater than `MAX_FM_DIM`, the job goes to REPORT with `done_err` = BAD_DIM and `done_cycles` = 0. No start is issued.
  - Otherwise the next state is ISSUE.
- **ISSUE.** Asserts `eng_start` for exactly this one cycle. Clears the cycle counter to 1. Next state is WAIT_BUSY.
- **WAIT_BUSY.** Lasts exactly one cycle and increments the counter.
  - If `eng_idle` = 1, the engine did not start: go to REPORT with `done_err` = START_FAIL.
  - Otherwise go to RUN.
- **RUN.** Increments the counter every cycle. On the first cycle with `eng_idle` = 1, latches the count, which includes that cycle, and goes to REPORT.
- **REPORT.** Holds `done_valid` = 1 until `done_ready` = 1, then returns to IDLE.
- **Engine parameters.** `eng_*` outputs come from the active registers. They must not change from the pop until REPORT exits.
- **Counter width.** `done_cycles` saturates at 0xFFFFFFFF and does not wrap.
- **Reset values.** `cmd_ready` = 1, `eng_start` = 0, all `eng_*` parameters = 0, `done_valid` = 0, `done_tag`/`done_err`/`done_cycles` = 0, `busy` = 0, `pending` = 0, state = IDLE.
- **Reset mid-job.** Everything above returns to its reset value. The engine shares the same reset, so no cleanup sequence is required.

## Timing
- **Queue-to-start latency.** For a valid job with the engine idle: a push in cycle t gives a pop in t+1 and `eng_start` in t+2.
- **Back-to-back jobs.** The next pop happens no earlier than the cycle after REPORT completes its handshake.
- **Enqueue while full.** `cmd_ready` is low when the queue is full, even if a pop happens in the same cycle. Enqueue and pop in the same cycle leave `pending` unchanged.
- **Done handshake.** `done_*` are registered and stay stable while `done_valid` is high and `done_ready` is low.
- **No combinational paths.** There is no path from `cmd_valid` to `cmd_ready`, or from `done_ready` to `done_valid`.

## Structure
- **Shared header.** `conv2D_sched_defs.vh` holds the state encodings and the error codes `ERR_OK`, `ERR_BAD_DIM` and `ERR_START_FAIL`.
- **Command queue.** Built from the existing `fifo` module with `WIDTH` = TAGW+128 and `LOGDEPTH` = LOGDEPTH, plus a local occupancy counter for `pending`.
- **Registers.** All registers use the standard register cells (`REGISTER_R`, `REGISTER_R_CE`) adapted to the active-low asynchronous reset.

## Test plan
- **Single valid job.** Push tag=3, fm_dim=8; engine model drops idle one cycle after start and raises it 100 cycles later. Expect exactly one `eng_start` pulse 2 cycles after the push; `done_tag`=3, `done_err`=0, `done_cycles`=102.
- **Bad dimensions.** Push fm_dim=0, then fm_dim=MAX_FM_DIM+1. Expect no `eng_start`; two records with `done_err`=1 and `done_cycles`=0, in order.
- **Queue full and draining.** Push 5 jobs with the engine stalled busy. Expect `cmd_ready`=0 after the 4th push and `pending`=4. Release the engine: completions arrive with tags in FIFO order.
- **Start failure.** Engine model ignores start and keeps idle=1. Expect `done_err`=2 and `done_cycles`=2.
- **Done back-pressure.** Hold `done_ready`=0 for 20 cycles. Expect the record to stay stable, no new `eng_start`, and queued jobs to stay queued.
- **Flush and reset mid-job.** Assert `flush` with 3 jobs queued while a job runs: expect `pending`=0 and only the running job to complete. Then assert `rst` low mid-RUN: expect every output at its reset value immediately.
